// File: rtl/mem_ctrl_if.sv
// Bundle of MEM-stage request/response and external 8-bit RAM signals for mem_ctrl.
// slave is the controller's view; master is the pipeline/RAM environment's view.
interface mem_ctrl_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stallreq_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [7:0]  ram_data_o;
    logic [7:0]  ram_data_i;

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i, ram_data_i,
        output data_o, stallreq_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o
    );

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i, ram_data_i,
        input  data_o, stallreq_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Data-memory controller: serialises 32-bit loads/stores onto an 8-bit synchronous RAM.
// Optional one-entry load buffer enabled by defining MEMCTRL_WORD_BUF_EN.
module mem_ctrl #(
    parameter int RD_BYTES = 4
) (
    input  logic clk,
    input  logic rst,
    mem_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RDW  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int         RD_LAST_I = RD_BYTES - 1;
    localparam logic [1:0] RD_LAST   = 2'(RD_LAST_I);

    logic [2:0]  state_reg;
    logic [1:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  nbytes_reg;
    logic        ram_ce_reg;
    logic        ram_we_reg;
    logic [31:0] ram_addr_reg;
    logic [7:0]  ram_data_reg;

    logic [1:0]  cnt_inc;
    logic [2:0]  req_n;
    logic        cap_en;
    logic [1:0]  cap_lane;
    logic        buf_hit;
    logic [31:0] data_word;

    assign cnt_inc = cnt_reg + 2'd1;

    always_comb begin
        req_n = 3'd0;
        case (bus.sel_i)
            4'b0001: req_n = 3'd1;
            4'b0010: req_n = 3'd2;
            4'b0100: req_n = 3'd4;
            default: req_n = 3'd0;
        endcase
    end

    // RAM data lags its address by one cycle, so RD captures the previous lane.
    assign cap_en   = (state_reg == S_RD && cnt_reg != 2'd0) || (state_reg == S_RDW);
    assign cap_lane = (state_reg == S_RDW) ? RD_LAST : (cnt_reg - 2'd1);

`ifdef MEMCTRL_WORD_BUF_EN
    logic        buf_valid_reg;
    logic [31:0] buf_tag_reg;
    logic [31:0] buf_word_reg;
    logic [31:0] rdw_word;

    assign buf_hit = buf_valid_reg && (bus.addr_i == buf_tag_reg);

    always_comb begin
        rdw_word = data_word;
        rdw_word[8*RD_LAST_I +: 8] = bus.ram_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= 32'd0;
            buf_word_reg  <= 32'd0;
        end else if (state_reg == S_RDW) begin
            buf_valid_reg <= 1'b1;
            buf_tag_reg   <= addr_reg;
            buf_word_reg  <= rdw_word;
        end else if (state_reg == S_IDLE && bus.ce_i && bus.we_i) begin
            buf_valid_reg <= 1'b0;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 2'd0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            nbytes_reg   <= 3'd0;
            ram_ce_reg   <= 1'b0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= 32'd0;
            ram_data_reg <= 8'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.ce_i) begin
                        addr_reg <= bus.addr_i;
                        cnt_reg  <= 2'd0;
                        if (!bus.we_i) begin
                            if (buf_hit) begin
                                state_reg <= S_DONE;
                            end else begin
                                state_reg    <= S_RD;
                                ram_ce_reg   <= 1'b1;
                                ram_we_reg   <= 1'b0;
                                ram_addr_reg <= bus.addr_i;
                            end
                        end else begin
                            wdata_reg  <= bus.data_i;
                            nbytes_reg <= req_n;
                            if (req_n == 3'd0) begin
                                state_reg <= S_DONE;
                            end else begin
                                state_reg    <= S_WR;
                                ram_ce_reg   <= 1'b1;
                                ram_we_reg   <= 1'b1;
                                ram_addr_reg <= bus.addr_i;
                                ram_data_reg <= bus.data_i[7:0];
                            end
                        end
                    end
                end
                S_RD: begin
                    if (cnt_reg == RD_LAST) begin
                        state_reg  <= S_RDW;
                        ram_ce_reg <= 1'b0;
                    end else begin
                        cnt_reg      <= cnt_inc;
                        ram_addr_reg <= addr_reg + {30'd0, cnt_inc};
                    end
                end
                S_RDW: begin
                    state_reg <= S_DONE;
                end
                S_WR: begin
                    if ({1'b0, cnt_reg} == nbytes_reg - 3'd1) begin
                        state_reg  <= S_DONE;
                        ram_ce_reg <= 1'b0;
                        ram_we_reg <= 1'b0;
                    end else begin
                        cnt_reg      <= cnt_inc;
                        ram_addr_reg <= addr_reg + {30'd0, cnt_inc};
                        ram_data_reg <= wdata_reg[{cnt_inc, 3'b000} +: 8];
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    cnt_reg   <= 2'd0;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= 8'd0;
                end else if (cap_en && cap_lane == 2'(gi)) begin
                    lane_reg <= bus.ram_data_i;
`ifdef MEMCTRL_WORD_BUF_EN
                end else if (state_reg == S_IDLE && bus.ce_i && !bus.we_i && buf_hit) begin
                    lane_reg <= buf_word_reg[8*gi +: 8];
`endif
                end
            end
            assign data_word[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign bus.data_o     = data_word;
    assign bus.stallreq_o = (state_reg == S_IDLE && bus.ce_i) || (state_reg == S_RD) ||
                            (state_reg == S_RDW) || (state_reg == S_WR);
    assign bus.ram_ce_o   = ram_ce_reg;
    assign bus.ram_we_o   = ram_we_reg;
    assign bus.ram_addr_o = ram_addr_reg;
    assign bus.ram_data_o = ram_data_reg;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: randomized loads/stores against a cycle-timeline model and byte-array memory.
// Define MEMCTRL_WORD_BUF_EN here as for the RTL to model the load buffer.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if bus();
    mem_ctrl #(.RD_BYTES(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        bit          stall;
        bit          ce;
        bit          we;
        bit          chk_addr;
        logic [31:0] addr;
        bit          chk_wd;
        logic [7:0]  wd;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] seen_addr[$];
    logic [7:0]  ram_mem[int unsigned];
    logic [7:0]  model_mem[int unsigned];
    logic [31:0] last_word;
    bit          buf_valid;
    logic [31:0] buf_tag;
    int          errors = 0;
    int          checks = 0;
    int          txn = 0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] mread(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_byte(a);
    endfunction

    function automatic exp_t mk(input bit stall, input bit ce, input bit we,
                                input bit ca, input logic [31:0] a,
                                input bit cw, input logic [7:0] wd,
                                input bit cd, input logic [31:0] d);
        exp_t e;
        e.stall = stall; e.ce = ce; e.we = we; e.chk_addr = ca; e.addr = a;
        e.chk_wd = cw; e.wd = wd; e.chk_data = cd; e.data = d;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous byte RAM: data returned the cycle after the address.
    initial bus.ram_data_i = 8'd0;
    always @(posedge clk) begin
        if (bus.ram_ce_o) begin
            if (bus.ram_we_o) ram_mem[bus.ram_addr_o] = bus.ram_data_o;
            else              bus.ram_data_i <= ram_rd(bus.ram_addr_o);
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (bus.ram_ce_o) seen_addr.push_back(bus.ram_addr_o);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("stallreq_o", {31'd0, bus.stallreq_o}, {31'd0, e.stall});
            chk("ram_ce_o", {31'd0, bus.ram_ce_o}, {31'd0, e.ce});
            chk("ram_we_o", {31'd0, bus.ram_we_o}, {31'd0, e.we});
            if (e.chk_addr) chk("ram_addr_o", bus.ram_addr_o, e.addr);
            if (e.chk_wd)   chk("ram_data_o", {24'd0, bus.ram_data_o}, {24'd0, e.wd});
            if (e.chk_data) chk("data_o", bus.data_o, e.data);
        end
    end

    task automatic drive_req(input bit we, input logic [31:0] a, input logic [3:0] sel,
                             input logic [31:0] d);
        bus.ce_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.sel_i = sel; bus.data_i = d;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.ce_i = 1'b0; bus.we_i = 1'($urandom); bus.addr_i = $urandom;
        bus.sel_i = 4'($urandom); bus.data_i = $urandom;
        expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, last_word));
    endtask

    task automatic do_load(input logic [31:0] a, input bit flush);
        logic [31:0] w, old, mask, exp_d;
        bit hit;
        w = {mread(a + 32'd3), mread(a + 32'd2), mread(a + 32'd1), mread(a)};
        old = last_word;
        hit = 1'b0;
`ifdef MEMCTRL_WORD_BUF_EN
        hit = buf_valid && (a == buf_tag);
`endif
        txn++;
        $display("txn %0d: load  addr=%h word=%h hit=%0d flush=%0d", txn, a, w, hit, flush);
        if (hit) begin
            @(posedge clk); #1; drive_req(1'b0, a, 4'($urandom), $urandom);
            expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, old));
            @(posedge clk); #1;
            expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, w));
        end else begin
            for (int k = 0; k <= 6; k++) begin
                @(posedge clk); #1;
                if (k == 0) drive_req(1'b0, a, 4'($urandom), $urandom);
                else if (flush && k >= 2) bus.ce_i = 1'b0;
                // byte k-3 lands in data_o at cycle k (captures start at T+2)
                if (k <= 2)      mask = 32'd0;
                else if (k >= 6) mask = 32'hFFFFFFFF;
                else             mask = (32'd1 << (8 * (k - 2))) - 32'd1;
                exp_d = (w & mask) | (old & ~mask);
                expq.push_back(mk(k < 6, k >= 1 && k <= 4, 0, k >= 1 && k <= 4,
                                  a + 32'(k - 1), 0, 0, 1, exp_d));
            end
            buf_valid = 1'b1;
            buf_tag = a;
        end
        last_word = w;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
        int n;
        n = (sel == 4'b0001) ? 1 : (sel == 4'b0010) ? 2 : (sel == 4'b0100) ? 4 : 0;
        txn++;
        $display("txn %0d: store addr=%h sel=%b data=%h bytes=%0d", txn, a, sel, d, n);
        for (int k = 0; k <= n + 1; k++) begin
            @(posedge clk); #1;
            if (k == 0) drive_req(1'b1, a, sel, d);
            expq.push_back(mk(k <= n, k >= 1 && k <= n, k >= 1 && k <= n, k >= 1 && k <= n,
                              a + 32'(k - 1), k >= 1 && k <= n, d[8*((k >= 1) ? k - 1 : 0) +: 8],
                              1, last_word));
        end
        for (int i = 0; i < n; i++) model_mem[a + 32'(i)] = d[8*i +: 8];
        buf_valid = 1'b0;
    endtask

    // Word store aborted by a reset sampled at the end of its first write cycle.
    task automatic store_with_reset(input logic [31:0] a, input logic [31:0] d);
        txn++;
        $display("txn %0d: store addr=%h data=%h aborted by reset", txn, a, d);
        @(posedge clk); #1; drive_req(1'b1, a, 4'b0100, d);
        expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, last_word));
        @(posedge clk); #1; rst = 1'b1;
        expq.push_back(mk(1, 1, 1, 1, a, 1, d[7:0], 1, last_word));
        @(posedge clk); #1; rst = 1'b0; bus.ce_i = 1'b0;
        expq.push_back(mk(0, 0, 0, 1, 32'd0, 1, 8'd0, 1, 32'd0));
        model_mem[a] = d[7:0];
        last_word = 32'd0;
        buf_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_exp[4];
        logic [31:0] a;
        logic [3:0]  sel;
        wrap_exp[0] = 32'hFFFFFFFE; wrap_exp[1] = 32'hFFFFFFFF;
        wrap_exp[2] = 32'h00000000; wrap_exp[3] = 32'h00000001;
        last_word = 32'd0;
        buf_valid = 1'b0;
        buf_tag = 32'd0;
        rst = 1'b1;
        bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'd0; bus.sel_i = 4'd0; bus.data_i = 32'd0;

        // Reset state; stall follows ce_i while idle.
        @(posedge clk); #1; bus.ce_i = 1'b1;
        expq.push_back(mk(1, 0, 0, 1, 32'd0, 1, 8'd0, 1, 32'd0));
        @(posedge clk); #1; rst = 1'b0; bus.ce_i = 1'b0;
        expq.push_back(mk(0, 0, 0, 1, 32'd0, 1, 8'd0, 1, 32'd0));

        for (int i = 0; i < 4; i++) begin
            ram_mem[32'h100 + i]   = 8'(8'h11 * (i + 1));
            model_mem[32'h100 + i] = 8'(8'h11 * (i + 1));
        end
        do_load(32'h100, 1'b0);
        @(negedge clk); chk("lit_load_word", bus.data_o, 32'h44332211);

        do_store(32'h200, 4'b0010, 32'hDEADBEEF);
        @(negedge clk);
        chk("lit_wr_0x200", {24'd0, ram_rd(32'h200)}, 32'h000000EF);
        chk("lit_wr_0x201", {24'd0, ram_rd(32'h201)}, 32'h000000BE);
        chk("lit_no_wr_0x202", {31'd0, ram_mem.exists(32'h202)}, 32'd0);

        seen_addr.delete();
        do_load(32'hFFFFFFFE, 1'b0);
        @(negedge clk);
        chk("lit_wrap_count", 32'(seen_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++) chk("lit_wrap_addr", seen_addr[i], wrap_exp[i]);

        do_store(32'h300, 4'b1000, 32'h12345678);
        @(negedge clk); chk("lit_bad_sel_no_write", {31'd0, ram_mem.exists(32'h300)}, 32'd0);

        idle_cycle();
        store_with_reset(32'h400, 32'hCAFEF00D);
        @(negedge clk);
        chk("lit_rst_byte0", {24'd0, ram_rd(32'h400)}, 32'h0000000D);
        chk("lit_rst_no_byte1", {31'd0, ram_mem.exists(32'h401)}, 32'd0);
        do_load(32'h400, 1'b0);

        do_load(32'h100, 1'b0);
        @(negedge clk); chk("lit_repeat_load", bus.data_o, 32'h44332211);
        do_store(32'h500, 4'b0001, 32'h000000A5);
        do_load(32'h100, 1'b0);

        for (int t = 0; t < 250; t++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                             : 32'h1000 + 32'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0, 1, 2: do_load(a, $urandom_range(0, 4) == 0);
                3, 4: begin
                    sel = 4'b0001 << $urandom_range(0, 2);
                    do_store(a, sel, $urandom);
                end
                default: do_store(a, 4'($urandom), $urandom);
            endcase
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
